// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants for the systolic PE datapath.
// Adder width/segment defaults and the stage-count helper.
package systolic_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADD_SEG    = 4;

  function automatic int add_stages(
    input int width,
    input int seg
  );
    if (seg < 1 || seg > width) begin
      return 1;
    end
    return width / seg;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// adder_segment: combinational SEG-bit ripple-carry slice.
// Also exposes the carry into the slice MSB for overflow.
import systolic_pkg::*;

module adder_segment #(
  parameter int SEG = ADD_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | ((a[i] ^ b[i]) & c[i]);
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: segmented-carry add/sub, one SEG slice per stage.
// Operands skew forward, partial sums de-skew alongside the carry.
import systolic_pkg::*;

module pipelined_adder #(
  parameter int WIDTH = DATA_WIDTH,
  parameter int SEG   = ADD_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG_NZ = (SEG < 1) ? 1 : SEG;
  localparam int STAGES = add_stages(WIDTH, SEG);

  if (SEG < 1 || SEG > WIDTH
      || (WIDTH % SEG_NZ) != 0) begin : g_bad_param
    $error("pipelined_adder: WIDTH must be a multiple of SEG");
  end

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic             v_i;
    logic             c_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic [WIDTH-1:0] s_n;
    logic [SEG-1:0]   seg_s;
    logic             seg_c;
    logic             seg_m;
    logic             v_q;
    logic             c_q;
    logic             m_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             unused_q;

    if (k == 0) begin : g_entry
      assign v_i = in_valid;
      assign a_i = in_a;
      assign b_i = in_sub ? ~in_b : in_b;
      assign c_i = in_sub | in_cin;
      assign s_i = '0;
    end else begin : g_chain
      assign v_i = g_st[k-1].v_q;
      assign a_i = g_st[k-1].a_q;
      assign b_i = g_st[k-1].b_q;
      assign c_i = g_st[k-1].c_q;
      assign s_i = g_st[k-1].s_q;
    end

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a        (a_i[k*SEG +: SEG]),
      .b        (b_i[k*SEG +: SEG]),
      .cin      (c_i),
      .sum      (seg_s),
      .cout     (seg_c),
      .c_msb_in (seg_m)
    );

    // Splice this stage's slice into the travelling partial sum.
    always_comb begin
      s_n = s_i;
      s_n[k*SEG +: SEG] = seg_s;
    end

    // Stage register: holds on stall, bubbles pass with v_q = 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        m_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        c_q <= seg_c;
        m_q <= seg_m;
        a_q <= a_i;
        b_q <= b_i;
        s_q <= s_n;
      end
    end

    assign unused_q = ^{a_q, b_q, m_q};
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign out_sum   = g_st[STAGES-1].s_q;
  assign out_cout  = g_st[STAGES-1].c_q;
  assign out_ovf   = g_st[STAGES-1].c_q
                   ^ g_st[STAGES-1].m_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: three adder configs against a
// transaction-level pipeline model with arithmetic reference.
module tb_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sub;
  logic        in_cin;
  logic        out_ready;
  logic [31:0] a_drv;
  logic [31:0] b_drv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  oc;
  logic [2:0]  oo;
  logic [15:0] s16;
  logic [7:0]  s8;
  logic [31:0] s32;
  logic [31:0] os [3];

  logic        mv [3][8];
  logic [31:0] ms [3][8];
  logic        mc [3][8];
  logic        mo [3][8];

  int   total = 0;
  int   bad   = 0;
  logic acc0;

  always #5 clk = ~clk;

  assign os[0] = {16'd0, s16};
  assign os[1] = {24'd0, s8};
  assign os[2] = s32;

  pipelined_adder #(.WIDTH(16), .SEG(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_a(a_drv[15:0]), .in_b(b_drv[15:0]),
    .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_sum(s16), .out_cout(oc[0]), .out_ovf(oo[0])
  );

  pipelined_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_a(a_drv[7:0]), .in_b(b_drv[7:0]),
    .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_sum(s8), .out_cout(oc[1]), .out_ovf(oo[1])
  );

  pipelined_adder #(.WIDTH(32), .SEG(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[2]),
    .in_a(a_drv), .in_b(b_drv),
    .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_sum(s32), .out_cout(oc[2]), .out_ovf(oo[2])
  );

  function automatic int wid(input int d);
    return (d == 0) ? 16 : (d == 1) ? 8 : 32;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 8;
  endfunction

  // Plain arithmetic reference: {ovf, cout, sum}.
  function automatic logic [33:0] ref_add(
    input int w, input logic [31:0] a, input logic [31:0] b,
    input logic sub, input logic cin
  );
    logic [63:0] mask;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [63:0] full;
    logic        ovf;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    full = aa + bb + (sub ? 64'd1 : {63'd0, cin});
    ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return {ovf, full[w], full[31:0] & mask[31:0]};
  endfunction

  task automatic chk(input string tag, input int d,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s dut%0d got=%h exp=%h", tag, d, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        mv[d][i] = 1'b0;
        ms[d][i] = '0;
        mc[d][i] = 1'b0;
        mo[d][i] = 1'b0;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_valid"}, d, 32'(ov[d]), 32'd0);
      chk({tag, "_sum"}, d, os[d], 32'd0);
      chk({tag, "_cout"}, d, 32'(oc[d]), 32'd0);
      chk({tag, "_ovf"}, d, 32'(oo[d]), 32'd0);
      chk({tag, "_ready"}, d, 32'(ir[d]), 32'd1);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic sub,
                      input logic cin, input logic rdy);
    logic        adv [3];
    logic [33:0] r;
    int          t;
    @(negedge clk);
    in_valid  = v;
    a_drv     = a;
    b_drv     = b;
    in_sub    = sub;
    in_cin    = cin;
    out_ready = rdy;
    #1;
    for (int d = 0; d < 3; d++) begin
      t      = lat(d) - 1;
      adv[d] = !mv[d][t] || rdy;
      chk("in_ready", d, 32'(ir[d]), 32'(adv[d]));
      chk("out_valid", d, 32'(ov[d]), 32'(mv[d][t]));
      if (mv[d][t]) begin
        chk("sum", d, os[d], ms[d][t]);
        chk("cout", d, 32'(oc[d]), 32'(mc[d][t]));
        chk("ovf", d, 32'(oo[d]), 32'(mo[d][t]));
      end
    end
    acc0 = adv[0] && v;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (adv[d]) begin
        for (int i = lat(d) - 1; i > 0; i--) begin
          mv[d][i] = mv[d][i-1];
          ms[d][i] = ms[d][i-1];
          mc[d][i] = mc[d][i-1];
          mo[d][i] = mo[d][i-1];
        end
        r = ref_add(wid(d), a, b, sub, cin);
        mv[d][0] = v;
        ms[d][0] = r[31:0];
        mc[d][0] = r[32];
        mo[d][0] = r[33];
      end
    end
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic sub,
                          input logic cin, input logic [15:0] es,
                          input logic ec, input logic eo);
    int n;
    step(1'b1, a, b, sub, cin, 1'b1);
    n = 0;
    while (!ov[0] && n < 20) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk({tag, "_lat"}, 0, 32'(n), 32'd3);
    chk({tag, "_sum"}, 0, os[0], {16'd0, es});
    chk({tag, "_cout"}, 0, 32'(oc[0]), 32'(ec));
    chk({tag, "_ovf"}, 0, 32'(oo[0]), 32'(eo));
  endtask

  initial begin
    int   idx;
    logic rdy;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_drv     = '0;
    b_drv     = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    acc0      = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    directed("add", 32'h1234, 32'h1111, 1'b0, 1'b0,
             16'h2345, 1'b0, 1'b0);
    directed("carry", 32'hFFFF, 32'h0000, 1'b0, 1'b1,
             16'h0000, 1'b1, 1'b0);
    directed("povf", 32'h7FFF, 32'h0001, 1'b0, 1'b0,
             16'h8000, 1'b0, 1'b1);
    directed("sub", 32'h0005, 32'h0007, 1'b1, 1'b0,
             16'hFFFE, 1'b0, 1'b0);
    directed("subovf", 32'h8000, 32'h0001, 1'b1, 1'b1,
             16'h7FFF, 1'b1, 1'b1);
    repeat (10) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    idx = 0;
    for (int c = 0; c < 40; c++) begin
      rdy = !(c >= 5 && c < 8);
      step(idx < 8, 32'h0101 * (idx + 1), 32'h0F0F + idx,
           1'(idx % 2), 1'(idx % 3 == 0), rdy);
      if (acc0) idx++;
    end
    chk("stream_cnt", 0, 32'(idx), 32'd8);

    repeat (3) step(1'b1, 32'hA5A5_1234, 32'h5A5A_4321,
                    1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0);
    end
    repeat (12) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, segmented-carry pipelined adder/subtractor for the systolic processing element datapath.
- Splits a WIDTH-bit ripple-carry add into WIDTH/SEG pipeline stages of SEG bits each; carry is registered between stages.
- Operands are skewed in and results de-skewed out, giving one result per cycle at full throughput.
- Valid/ready handshake with a global stall; add/sub mode per transaction; carry-out and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG; must satisfy 1 <= SEG <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand transaction valid.
- in_ready  output  1  block accepts a transaction this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0: A+B+in_cin; 1: A-B (in_cin ignored).
- in_cin  input  1  carry-in, used in add mode only.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow.
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync deassert expected externally): all stage valid bits = 0, all data, carry and skew registers = 0. out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0. in_ready = 1 while out_valid = 0.
- Reset mid-operation: all in-flight transactions are discarded; nothing is emitted after rst_n rises until new inputs arrive.
- Operand conditioning at entry:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and b_eff with the carry registered from stage k-1 (c0 for k=0).
  - Higher operand slices travel in skew registers.
  - Lower result slices travel in de-skew registers.
- Latency: a transaction accepted at edge N (in_valid & in_ready) appears with out_valid = 1 after edge N+STAGES-1 when no stall occurs. With STAGES = 1 it appears after edge N, i.e. registered output.
- Global stall: advance = ~out_valid | out_ready. in_ready = advance.
  - When advance = 0, every pipeline register holds, including the output.
  - Bubbles are carried as valid = 0 and are not compacted.
  - out_* remain stable while out_valid = 1 and out_ready = 0.
- Flags, computed in the last stage:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry-into-MSB XOR carry-out-of-MSB.
- Simultaneous accept and emit in the same cycle is legal and sustains 1 transaction per cycle.
- in_valid = 0 while advancing inserts a bubble; the data registers may update but the valid bit is 0.
- Invalid parameters (WIDTH % SEG != 0, or SEG = 0) cause an elaboration error via a generate-time check.

Decomposition:
- Shared package, systolic_pkg: default DATA_WIDTH = 16, default ADD_SEG = 4, and a STAGES helper function (WIDTH/SEG).
- One sub-module, adder_segment: a combinational SEG-bit ripple-carry slice built from 1-bit full-adder cells (sum = a^b^c, carry = ab | (a^b)c), with outputs sum[SEG], cout, and c_msb_in (carry into the slice MSB, used for overflow).
- pipelined_adder generates STAGES instances of adder_segment plus the skew/de-skew and valid registers.

Test Plan (WIDTH=16, SEG=4, so latency 4):
- Basic add: A=0x1234, B=0x1111, sub=0, cin=0, out_ready=1 -> 4 cycles later sum=0x2345, cout=0, ovf=0.
- Carry chain across all segments: A=0xFFFF, B=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Then A=0x7FFF, B=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: A=0x0005, B=0x0007, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then A=0x8000, B=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Back-to-back and stall: stream 8 consecutive transactions; hold out_ready=0 for 3 cycles mid-stream. Required: in_ready=0 during the stall, out_sum stable, no loss or duplication, results in order, throughput 1/cycle outside the stall.
- Reset mid-flight: issue 3 transactions, assert rst_n=0 at cycle 2 for 1 cycle. Required: out_valid=0 and out_sum=0 immediately on assertion, and no stale result ever emerges afterward.
- Random compare: 10k random A, B, sub, cin with random out_ready/in_valid against a reference model. Repeat with parameter sets WIDTH=8/SEG=8 (latency 1) and WIDTH=32/SEG=4 (latency 8).
